sync_fifo_prog: RTL and testbench

- Single-clock, parametrised successor to the team's asynchronous FIFO, for blocks that share one clock domain. It needs no pointer synchronisers.
- Generalises depth and width and adds the following:
  - selectable standard or first-word-fall-through (FWFT) read mode
  - runtime-programmable almost-full and almost-empty thresholds
  - an exact occupancy count
  - synchronous flush
  - sticky overflow and underflow error flags
- Sits between producer and consumer pipelines inside one clock domain.

---
 rtl/sync_fifo_pkg.sv | 22 ++
 rtl/sync_fifo_mem.sv | 39 +++
 rtl/sync_fifo_prog.sv | 136 +++++++++++++
 tb/tb_sync_fifo_prog.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// -----------------------------------------------------------------------------
// sync_fifo_pkg
// Shared types and constants for the single-clock programmable FIFO.
//   fifo_mode_e : read-mode selector (standard registered read or FWFT)
//   DEFAULT_*   : default geometry
//   ptr_width() : address width derived from the depth
// -----------------------------------------------------------------------------
package sync_fifo_pkg;

    typedef enum logic {
        MODE_STD  = 1'b0,
        MODE_FWFT = 1'b1
    } fifo_mode_e;

    localparam int DEFAULT_DEPTH      = 16;
    localparam int DEFAULT_DATA_WIDTH = 8;

    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// -----------------------------------------------------------------------------
// sync_fifo_mem
// DEPTH x DATA_WIDTH storage: one synchronous write port, one combinational
// read port.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data (combinational from raddr)
// -----------------------------------------------------------------------------
module sync_fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = ptr_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // NOTE: storage has no reset; occupancy tracking guarantees stale words
    // are never presented, and an unreset array maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo_prog.sv
// -----------------------------------------------------------------------------
// sync_fifo_prog
// Single-clock FIFO with standard or first-word-fall-through read, programmable
// almost-full / almost-empty thresholds, exact occupancy, synchronous flush and
// sticky overflow / underflow flags.
//   clk, rst       : clock, synchronous active-high reset
//   flush          : synchronous clear of contents and error flags
//   write_enable   : push request, data_in is the pushed word
//   read_enable    : pop request (acknowledge of the presented word in FWFT)
//   data_out       : read data
//   afull_thresh   : almost_full when word_count >= afull_thresh
//   aempty_thresh  : almost_empty when word_count <= aempty_thresh
//   word_count     : occupancy 0..DEPTH
//   wfull, rempty, half_full, almost_full, almost_empty : registered flags
//   overflow, underflow : sticky error flags
// -----------------------------------------------------------------------------
module sync_fifo_prog
    import sync_fifo_pkg::*;
#(
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int PTR_WIDTH  = ptr_width(DEPTH),
    parameter int FWFT       = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  write_enable,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  read_enable,
    output logic [DATA_WIDTH-1:0] data_out,
    input  logic [PTR_WIDTH:0]    afull_thresh,
    input  logic [PTR_WIDTH:0]    aempty_thresh,
    output logic [PTR_WIDTH:0]    word_count,
    output logic                  wfull,
    output logic                  rempty,
    output logic                  half_full,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int                 CW      = PTR_WIDTH + 1;
    localparam logic [CW-1:0]      FULL_C  = CW'(DEPTH);
    localparam logic [CW-1:0]      HALF_C  = CW'(DEPTH / 2);
    localparam logic [PTR_WIDTH-1:0] PTR_ONE = PTR_WIDTH'(1);

    logic [PTR_WIDTH-1:0]  wptr_q, rptr_q;
    logic [CW-1:0]         count_q, count_d;
    logic                  wfull_q, rempty_q, half_full_q;
    logic                  almost_full_q, almost_empty_q;
    logic                  overflow_q, underflow_q;
    logic                  wr_acc, rd_acc, clear;
    logic [DATA_WIDTH-1:0] rdata;

    // Reset and flush share one clear path; both discard same-cycle requests.
    assign clear = rst | flush;

    // NOTE: every signal written here gets a value before any branch, so no
    // latch can be inferred.
    always_comb begin
        wr_acc  = write_enable & ~wfull_q;
        rd_acc  = read_enable & ~rempty_q;
        count_d = count_q + {{PTR_WIDTH{1'b0}}, wr_acc} - {{PTR_WIDTH{1'b0}}, rd_acc};
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (clear) begin
            wptr_q         <= '0;
            rptr_q         <= '0;
            count_q        <= '0;
            wfull_q        <= 1'b0;
            rempty_q       <= 1'b1;
            half_full_q    <= 1'b0;
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
        end else begin
            if (wr_acc) wptr_q <= wptr_q + PTR_ONE;
            if (rd_acc) rptr_q <= rptr_q + PTR_ONE;
            count_q <= count_d;
            // Flags are derived from the next count so they move with word_count.
            wfull_q        <= (count_d == FULL_C);
            rempty_q       <= (count_d == '0);
            half_full_q    <= (count_d >= HALF_C);
            almost_full_q  <= (count_d >= afull_thresh);
            almost_empty_q <= (count_d <= aempty_thresh);
            overflow_q     <= overflow_q  | (write_enable & wfull_q);
            underflow_q    <= underflow_q | (read_enable & rempty_q);
        end
    end

    sync_fifo_mem #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (PTR_WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc & ~clear),
        .waddr (wptr_q),
        .wdata (data_in),
        .raddr (rptr_q),
        .rdata (rdata)
    );

    generate
        if (FWFT == int'(MODE_FWFT)) begin : g_fwft
            // Head word is presented as soon as the FIFO is non-empty.
            assign data_out = rempty_q ? '0 : rdata;
        end else begin : g_std
            logic [DATA_WIDTH-1:0] data_q;
            always_ff @(posedge clk) begin
                if (clear) begin
                    data_q <= '0;
                end else if (rd_acc) begin
                    data_q <= rdata;
                end
            end
            assign data_out = data_q;
        end
    endgenerate

    assign word_count   = count_q;
    assign wfull        = wfull_q;
    assign rempty       = rempty_q;
    assign half_full    = half_full_q;
    assign almost_full  = almost_full_q;
    assign almost_empty = almost_empty_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_prog.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_prog
// Drives a standard-read and an FWFT instance (DEPTH=8) with identical
// stimulus and compares both against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_sync_fifo_prog;

    localparam int DEPTH = 8;
    localparam int DW    = 8;
    localparam int CW    = 4;

    logic          clk = 1'b0;
    logic          rst, flush, write_enable, read_enable;
    logic [DW-1:0] data_in;
    logic [CW-1:0] afull_thresh, aempty_thresh;

    logic [DW-1:0] s_dout, f_dout;
    logic [CW-1:0] s_cnt, f_cnt;
    logic s_full, s_empty, s_hf, s_af, s_ae, s_ovf, s_unf;
    logic f_full, f_empty, f_hf, f_af, f_ae, f_ovf, f_unf;

    always #5 clk = ~clk;

    sync_fifo_prog #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .FWFT(0)) dut_std (
        .clk(clk), .rst(rst), .flush(flush),
        .write_enable(write_enable), .data_in(data_in),
        .read_enable(read_enable), .data_out(s_dout),
        .afull_thresh(afull_thresh), .aempty_thresh(aempty_thresh),
        .word_count(s_cnt), .wfull(s_full), .rempty(s_empty),
        .half_full(s_hf), .almost_full(s_af), .almost_empty(s_ae),
        .overflow(s_ovf), .underflow(s_unf)
    );

    sync_fifo_prog #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .FWFT(1)) dut_fwft (
        .clk(clk), .rst(rst), .flush(flush),
        .write_enable(write_enable), .data_in(data_in),
        .read_enable(read_enable), .data_out(f_dout),
        .afull_thresh(afull_thresh), .aempty_thresh(aempty_thresh),
        .word_count(f_cnt), .wfull(f_full), .rempty(f_empty),
        .half_full(f_hf), .almost_full(f_af), .almost_empty(f_ae),
        .overflow(f_ovf), .underflow(f_unf)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [DW-1:0] sb[$];
    int            mcount;
    logic          m_ovf, m_unf;
    logic [DW-1:0] m_std;

    typedef struct {
        logic          we;
        logic [DW-1:0] din;
        logic          re;
        int            cnt;
        logic          full, empty, hf, af, ae, ovf;
    } vec_t;

    vec_t tbl[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        logic [DW-1:0] f_exp;
        f_exp = (mcount > 0) ? sb[0] : '0;
        check("count",        32'(s_cnt),  32'(mcount));
        check("fwft_count",   32'(f_cnt),  32'(mcount));
        check("wfull",        32'(s_full), 32'(mcount == DEPTH));
        check("rempty",       32'(s_empty), 32'(mcount == 0));
        check("fwft_rempty",  32'(f_empty), 32'(mcount == 0));
        check("half_full",    32'(s_hf),   32'(mcount >= DEPTH / 2));
        check("almost_full",  32'(s_af),   32'(mcount >= int'(afull_thresh)));
        check("almost_empty", 32'(s_ae),   32'(mcount <= int'(aempty_thresh)));
        check("overflow",     32'(s_ovf),  32'(m_ovf));
        check("underflow",    32'(s_unf),  32'(m_unf));
        check("fwft_overflow", 32'(f_ovf), 32'(m_ovf));
        check("std_data",     32'(s_dout), 32'(m_std));
        check("fwft_data",    32'(f_dout), 32'(f_exp));
    endtask

    // One clock cycle of traffic; model updated from its own occupancy.
    task automatic step(input logic we, input logic [DW-1:0] din, input logic re);
        logic wacc, racc;
        wacc = we && (mcount < DEPTH);
        racc = re && (mcount > 0);
        if (we && !wacc) m_ovf = 1'b1;
        if (re && !racc) m_unf = 1'b1;
        if (racc) m_std = sb.pop_front();
        if (wacc) sb.push_back(din);
        mcount = mcount + int'(wacc) - int'(racc);
        write_enable = we;
        data_in      = din;
        read_enable  = re;
        @(posedge clk);
        #1;
        write_enable = 1'b0;
        read_enable  = 1'b0;
        compare_all();
    endtask

    // Reset or flush for one cycle, optionally with a write that must be dropped.
    task automatic clear(input logic use_rst, input logic we, input logic [DW-1:0] din);
        rst          = use_rst;
        flush        = !use_rst;
        write_enable = we;
        data_in      = din;
        read_enable  = 1'b0;
        @(posedge clk);
        #1;
        rst          = 1'b0;
        flush        = 1'b0;
        write_enable = 1'b0;
        sb.delete();
        mcount = 0;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
        m_std  = '0;
        compare_all();
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; write_enable = 1'b0; read_enable = 1'b0;
        data_in = '0; afull_thresh = 4'd6; aempty_thresh = 4'd2;
        mcount = 0; m_ovf = 1'b0; m_unf = 1'b0; m_std = '0;

        //            we  din    re cnt full emp hf  af  ae  ovf
        tbl[0] = '{1'b1, 8'h01, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[1] = '{1'b1, 8'h02, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{1'b1, 8'h03, 1'b0, 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 8'h04, 1'b0, 4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 8'h05, 1'b0, 5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 8'h06, 1'b0, 6, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 8'h07, 1'b0, 7, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[7] = '{1'b1, 8'h08, 1'b0, 8, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[8] = '{1'b1, 8'h09, 1'b0, 8, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

        // Reset state
        clear(1'b1, 1'b0, 8'h00);
        check("rst_almost_empty", 32'(s_ae), 32'd1);
        check("rst_data_out",     32'(s_dout), 32'd0);

        // Fill from empty, ninth write overflows
        for (int i = 0; i < 9; i++) begin
            step(tbl[i].we, tbl[i].din, tbl[i].re);
            check("tbl_count", 32'(s_cnt),   32'(tbl[i].cnt));
            check("tbl_full",  32'(s_full),  32'(tbl[i].full));
            check("tbl_empty", 32'(s_empty), 32'(tbl[i].empty));
            check("tbl_hf",    32'(s_hf),    32'(tbl[i].hf));
            check("tbl_af",    32'(s_af),    32'(tbl[i].af));
            check("tbl_ae",    32'(s_ae),    32'(tbl[i].ae));
            check("tbl_ovf",   32'(s_ovf),   32'(tbl[i].ovf));
        end

        // Threshold boundaries at full: equal then beyond the legal range
        afull_thresh = 4'd8;
        step(1'b0, 8'h00, 1'b0);
        afull_thresh = 4'd9;
        step(1'b0, 8'h00, 1'b0);
        afull_thresh = 4'd6;

        // Drain, then a ninth read underflows and data_out holds
        for (int i = 0; i < 9; i++) step(1'b0, 8'h00, 1'b1);
        check("hold_last", 32'(s_dout), 32'h08);

        // almost_empty with threshold 0
        aempty_thresh = 4'd0;
        step(1'b0, 8'h00, 1'b0);
        step(1'b1, 8'h42, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        aempty_thresh = 4'd2;

        // Fall-through of a single word, then acknowledge it
        clear(1'b0, 1'b0, 8'h00);
        step(1'b1, 8'hA5, 1'b0);
        check("fwft_first_word", 32'(f_dout), 32'hA5);
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        check("fwft_after_ack", 32'(f_dout), 32'h00);

        // Full with both enables: read wins, write overflows
        clear(1'b0, 1'b0, 8'h00);
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(8'h10 + i), 1'b0);
        step(1'b1, 8'hEE, 1'b1);
        check("full_both_count", 32'(s_cnt), 32'd7);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h30 + i), 1'b1);

        // Wrap-around at a steady occupancy of 3
        step(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b1, 8'(8'h50 + i), 1'b1);
        check("wrap_count", 32'(s_cnt), 32'd3);
        for (int i = 0; i < DEPTH && mcount > 0; i++) step(1'b0, 8'h00, 1'b1);

        // Flush at count 5 with a write that must be dropped
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(8'h60 + i), 1'b0);
        step(1'b1, 8'hFF, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);
        clear(1'b0, 1'b1, 8'hDD);
        check("flush_ovf_cleared", 32'(s_ovf), 32'd0);
        step(1'b1, 8'h77, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        check("post_flush_data", 32'(s_dout), 32'h77);

        // Reset mid-burst with a write that must be dropped
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h80 + i), 1'b0);
        clear(1'b1, 1'b1, 8'hCC);
        step(1'b1, 8'h99, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        check("post_rst_data", 32'(s_dout), 32'h99);
        step(1'b0, 8'h00, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
